// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the serializer slice.
package serdes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Level held on the serial line when no frame bit is being driven.
    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

    // Bit counter width: $clog2(w), never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bundle: upstream handshake plus serial-side outputs.
interface piso_serializer_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_done;
    logic             busy;

    // Upstream producer / observer side.
    modport master (
        output in_data, in_valid,
        input  in_ready, ser_out, ser_valid, frame_done, busy
    );

    // Serializer side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_out, ser_valid, frame_done, busy
    );
endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Loadable down-counter with zero flags; saturates at zero instead of wrapping.
module ser_bit_counter
    import serdes_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     load,
    input  logic [cnt_w(WIDTH)-1:0]  load_val,
    input  logic                     dec,
    output logic                     zero,
    output logic                     zero_nxt
);
    localparam int CW = cnt_w(WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;

    // Load wins over decrement; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // zero_nxt lets the parent register flags that must line up with the count.
    assign zero     = (cnt_q == '0);
    assign zero_nxt = (cnt_d == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out word serializer with valid/ready input and optional
// inter-frame gap. All outputs except busy come straight from flops.
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic               clk,
    input  logic               rstn,
    piso_serializer_if.slave   bus
);
    localparam int               CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_done_q, frame_done_d;

    logic accept;
    logic load_word, dec_bit, load_gap;
    logic bit_zero, bit_zero_nxt;

    // Bit currently presented on the line for a given shift register value.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Advance the shift register by one bit in the configured direction.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign accept = bus.in_valid && in_ready_q;

    ser_bit_counter #(.WIDTH(WIDTH)) u_bit_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (load_word),
        .load_val (LAST_BIT),
        .dec      (dec_bit),
        .zero     (bit_zero),
        .zero_nxt (bit_zero_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the load/decrement strobes that go with each transition.
    always_comb begin
        state_d   = state_q;
        load_word = 1'b0;
        dec_bit   = 1'b0;
        load_gap  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    load_word = 1'b1;
                end
            end
            SHIFT: begin
                if (!bit_zero) begin
                    dec_bit = 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    state_d  = GAP;
                    load_gap = 1'b1;
                end else if (accept) begin
                    // Back-to-back reload: next word's first bit follows with no bubble.
                    load_word = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs, all derived from the upcoming state so
    // each flop shows the value belonging to the cycle it is entering.
    always_comb begin
        shreg_d = shreg_q;
        if (load_word) begin
            shreg_d = bus.in_data;
        end else if (dec_bit) begin
            shreg_d = shift_once(shreg_q);
        end

        gap_cnt_d = gap_cnt_q;
        if (load_gap) begin
            gap_cnt_d = GAP_LOAD;
        end else if ((state_q == GAP) && (gap_cnt_q != 4'd0)) begin
            gap_cnt_d = gap_cnt_q - 4'd1;
        end

        ser_valid_d  = (state_d == SHIFT);
        ser_out_d    = ser_valid_d ? head_bit(shreg_d) : IDLE_LEVEL;
        frame_done_d = ser_valid_d && bit_zero_nxt;
        // Ready in the last-bit cycle only when a reload there is legal.
        in_ready_d   = (state_d == IDLE) ||
                       (ser_valid_d && bit_zero_nxt && (GAP_CYCLES == 0));
    end

    // Shift register, gap counter and output flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg_q      <= '0;
            gap_cnt_q    <= 4'd0;
            in_ready_q   <= 1'b0;
            ser_out_q    <= IDLE_LEVEL;
            ser_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            gap_cnt_q    <= gap_cnt_d;
            in_ready_q   <= in_ready_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.ser_out    = ser_out_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations share one stimulus stream.
// u0: MSB first, no gap, idle 0. u1: LSB first, no gap, idle 1.
// u2: MSB first, 2-cycle gap, idle 0.
module tb_piso_serializer;
    localparam int W = 4;

    int   G [3] = '{0, 0, 2};
    bit   M [3] = '{1'b1, 1'b0, 1'b1};
    logic IL[3] = '{1'b0, 1'b1, 1'b0};

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       vin  = 1'b0;
    logic [3:0] din  = 4'h0;

    int n_chk  = 0;
    int n_fail = 0;

    // Schedule model: frame start cycle and word per instance.
    int         cyc = 0;
    int         fs [3] = '{-100, -100, -100};
    logic [3:0] wd [3];

    // Observed outputs packed {in_ready, ser_valid, ser_out, frame_done, busy}.
    logic [4:0] act[3];

    logic [31:0] cap  [3];
    int          ncap [3];
    int          fdcnt[3];
    int          g2 = 0, tcyc = 0, fd_prev = 0, fd_last = 0;

    piso_serializer_if #(.WIDTH(4)) if0 ();
    piso_serializer_if #(.WIDTH(4)) if1 ();
    piso_serializer_if #(.WIDTH(4)) if2 ();

    assign if0.in_data = din;  assign if0.in_valid = vin;
    assign if1.in_data = din;  assign if1.in_valid = vin;
    assign if2.in_data = din;  assign if2.in_valid = vin;

    assign act[0] = {if0.in_ready, if0.ser_valid, if0.ser_out, if0.frame_done, if0.busy};
    assign act[1] = {if1.in_ready, if1.ser_valid, if1.ser_out, if1.frame_done, if1.busy};
    assign act[2] = {if2.in_ready, if2.ser_valid, if2.ser_out, if2.frame_done, if2.busy};

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0))
        u0 (.clk(clk), .rstn(rstn), .bus(if0));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1))
        u1 (.clk(clk), .rstn(rstn), .bus(if1));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0))
        u2 (.clk(clk), .rstn(rstn), .bus(if2));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    // Expected outputs in the current cycle: a frame occupies W cycles from its
    // start, then G idle-level cycles, then the block is ready again.
    function automatic logic [4:0] exp_v(input int n);
        int d;
        int bi;
        if (!rstn) return {1'b0, 1'b0, IL[n], 1'b0, 1'b0};
        d = cyc - fs[n];
        if (fs[n] >= 0 && d >= 0 && d < W) begin
            bi = M[n] ? (W - 1 - d) : d;
            return {(d == W - 1) && (G[n] == 0), 1'b1, wd[n][bi], d == W - 1, 1'b1};
        end
        if (fs[n] >= 0 && d < W + G[n]) return {1'b0, 1'b0, IL[n], 1'b0, 1'b1};
        return {cyc > 0, 1'b0, IL[n], 1'b0, 1'b0};
    endfunction

    function automatic logic acc(input int n);
        logic [4:0] e;
        e = exp_v(n);
        return e[4] && vin;
    endfunction

    // Model update: an accept at this edge starts a frame in the next cycle.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc <= 0;
            for (int n = 0; n < 3; n++) fs[n] <= -100;
        end else begin
            cyc <= cyc + 1;
            for (int n = 0; n < 3; n++) begin
                if (acc(n)) begin
                    fs[n] <= cyc + 1;
                    wd[n] <= din;
                end
            end
        end
    end

    task automatic compare_all();
        logic [4:0] e;
        tcyc++;
        for (int n = 0; n < 3; n++) begin
            e = exp_v(n);
            chk($sformatf("u%0d rdy_sv_so_fd_busy", n), {27'd0, act[n]}, {27'd0, e});
            if (act[n][3]) begin
                cap[n] = {cap[n][30:0], act[n][2]};
                ncap[n]++;
            end
            if (act[n][1]) fdcnt[n]++;
        end
        if (act[0][1]) begin
            fd_prev = fd_last;
            fd_last = tcyc;
        end
        if (act[2][0] && act[2][4:2] == 3'b000) g2++;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) compare_all();

    task automatic clr();
        for (int n = 0; n < 3; n++) begin
            cap[n]   = 32'd0;
            ncap[n]  = 0;
            fdcnt[n] = 0;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    // Wait (bounded) until instance n shows in_ready, then let the accept edge pass.
    task automatic wait_ready(input int n);
        for (int k = 0; k < 40 && !act[n][4]; k++) begin
            @(negedge clk);
            #1;
        end
        chk($sformatf("u%0d wait_ready", n), {31'd0, act[n][4]}, 32'd1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        clr();
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;
        #1 chk("ready_low_before_first_edge", {31'd0, act[0][4]}, 32'd0);
        idle(1);
        chk("ready_after_first_edge", {31'd0, act[0][4]}, 32'd1);

        // Single word 1011.
        clr();
        vin = 1'b1; din = 4'b1011;
        wait_ready(0);
        vin = 1'b0;
        idle(10);
        chk("u0 bits_1011", cap[0][3:0], 32'hB);
        chk("u0 bit_count", ncap[0], 4);
        chk("u0 frame_done_count", fdcnt[0], 1);
        chk("u1 lsb_first_bits", cap[1][3:0], 32'b1101);
        chk("u2 bits_1011", cap[2][3:0], 32'hB);

        // Back-to-back A then 3.
        clr();
        vin = 1'b1; din = 4'hA;
        wait_ready(0);
        din = 4'h3;
        wait_ready(0);
        vin = 1'b0;
        idle(10);
        chk("u0 b2b_bits", cap[0][7:0], 32'hA3);
        chk("u0 b2b_bit_count", ncap[0], 8);
        chk("u0 b2b_frame_done", fdcnt[0], 2);
        chk("u0 frame_done_spacing", fd_last - fd_prev, 4);

        // Gap instance with a stalled, changing word.
        clr();
        g2 = 0;
        vin = 1'b1; din = 4'h6;
        wait_ready(2);
        din = 4'h9;
        idle(2);
        din = 4'h7;
        wait_ready(2);
        chk("u2 gap_cycles", g2, 2);
        vin = 1'b0;
        idle(12);
        chk("u2 gap_bits", cap[2][7:0], 32'h67);
        chk("u2 gap_bit_count", ncap[2], 8);
        chk("u2 gap_frame_done", fdcnt[2], 2);

        // Reset in the middle of a frame.
        clr();
        vin = 1'b1; din = 4'hF;
        wait_ready(0);
        vin = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("u0 async_reset_outputs", {27'd0, act[0]}, 32'b00000);
        chk("u1 async_reset_outputs", {27'd0, act[1]}, 32'b00100);
        chk("u2 async_reset_outputs", {27'd0, act[2]}, 32'b00000);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        #1 chk("ready_low_after_release", {31'd0, act[0][4]}, 32'd0);
        idle(1);
        chk("ready_after_release_edge", {31'd0, act[0][4]}, 32'd1);
        chk("u0 no_frame_done_on_abort", fdcnt[0], 0);
        clr();
        vin = 1'b1; din = 4'h5;
        wait_ready(0);
        vin = 1'b0;
        idle(8);
        chk("u0 post_reset_bits", cap[0][3:0], 32'h5);
        chk("u0 post_reset_count", ncap[0], 4);
        chk("u1 post_reset_bits", cap[1][3:0], 32'b1010);
        chk("u0 post_reset_frame_done", fdcnt[0], 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
